// File: rtl/axis_packet_gen_if.sv
// ============================================================================
// Module      : axis_packet_gen_if
// Description : AXI-stream bundle used on the packet generator's output side.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface axis_packet_gen_if #(
    parameter int DW = 512,
    parameter int KW = DW / 8,
    parameter int UW = 1
) ();
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic [UW-1:0] tuser;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_packet_gen.sv
// ============================================================================
// Module      : axis_packet_gen
// Description : Synthetic AXI-stream frame generator with patterned payload,
//               final-beat tkeep and optional inter-packet idle gap.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module axis_packet_gen #(
    parameter int DW = 512,
    parameter int KW = DW / 8,
    parameter int UW = 1
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    input  wire logic        start,
    input  wire logic [15:0] packet_len,
    input  wire logic [31:0] packet_count,
    input  wire logic [7:0]  gap_cycles,
    output logic             busy,
    output logic [31:0]      packets_sent,
    axis_packet_gen_if.master axis_out
);

    localparam int C_LANES = DW / 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_count;
    logic [7:0]    r_gap;
    logic [7:0]    r_gap_cnt;
    logic [16:0]   r_beats;
    logic [KW-1:0] r_last_keep;
    logic [15:0]   r_seq;
    logic [16:0]   r_idx;
    logic [31:0]   r_sent;
    logic          r_busy;
    logic [DW-1:0] r_tdata;
    logic [KW-1:0] r_tkeep;
    logic          r_tlast;
    logic          r_tvalid;

    logic [16:0]   w_beats;
    logic [15:0]   w_rem;
    logic [KW-1:0] w_last_keep;
    logic [16:0]   w_idx_nxt;
    logic          w_mid_last;
    logic          w_first_last;
    logic [15:0]   w_seq_nxt;
    logic          w_hs;
    logic          w_start_ok;

    // 17-bit sum keeps ceil(len/KW) exact at len=65535
    assign w_beats      = (17'(packet_len) + 17'(KW - 1)) / 17'(KW);
    assign w_rem        = packet_len % 16'(KW);
    assign w_idx_nxt    = r_idx + 17'd1;
    assign w_mid_last   = (w_idx_nxt == r_beats - 17'd1);
    assign w_first_last = (r_beats == 17'd1);
    assign w_seq_nxt    = r_seq + 16'd1;
    assign w_hs         = r_tvalid && axis_out.tready;
    assign w_start_ok   = start && (packet_len != 16'd0) && (packet_count != 32'd0);

    always_comb begin
        w_last_keep = '0;
        for (int b = 0; b < KW; b++) begin
            w_last_keep[b] = (w_rem == 16'd0) || (16'(b) < w_rem);
        end
    end

    function automatic logic [DW-1:0] f_data(input logic [15:0] seq, input logic [11:0] idx);
        logic [DW-1:0] d;
        d = '0;
        for (int l = 0; l < C_LANES; l++) begin
            d[l*32 +: 32] = {seq, idx, 4'(l)};
        end
        return d;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_beats     <= '0;
            r_last_keep <= '0;
            r_seq       <= '0;
            r_idx       <= '0;
            r_sent      <= '0;
            r_busy      <= 1'b0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state     <= SEND;
                        r_count     <= packet_count;
                        r_gap       <= gap_cycles;
                        r_beats     <= w_beats;
                        r_last_keep <= w_last_keep;
                        r_seq       <= '0;
                        r_idx       <= '0;
                        r_sent      <= '0;
                        r_busy      <= 1'b1;
                        r_tvalid    <= 1'b1;
                        r_tdata     <= f_data(16'd0, 12'd0);
                        r_tkeep     <= (w_beats == 17'd1) ? w_last_keep : '1;
                        r_tlast     <= (w_beats == 17'd1);
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        if (r_tlast) begin
                            r_sent <= r_sent + 32'd1;
                            r_seq  <= w_seq_nxt;
                            r_idx  <= '0;
                            if (r_sent + 32'd1 == r_count) begin
                                r_state  <= IDLE;
                                r_busy   <= 1'b0;
                                r_tvalid <= 1'b0;
                                r_tlast  <= 1'b0;
                            end else if (r_gap != 8'd0) begin
                                r_state   <= GAP;
                                r_gap_cnt <= r_gap;
                                r_tvalid  <= 1'b0;
                                r_tlast   <= 1'b0;
                            end else begin
                                r_tdata <= f_data(w_seq_nxt, 12'd0);
                                r_tkeep <= w_first_last ? r_last_keep : '1;
                                r_tlast <= w_first_last;
                            end
                        end else begin
                            r_idx   <= w_idx_nxt;
                            r_tdata <= f_data(r_seq, w_idx_nxt[11:0]);
                            r_tkeep <= w_mid_last ? r_last_keep : '1;
                            r_tlast <= w_mid_last;
                        end
                    end
                end
                GAP: begin
                    // sequence number was already advanced on the final handshake
                    if (r_gap_cnt == 8'd1) begin
                        r_state  <= SEND;
                        r_tvalid <= 1'b1;
                        r_tdata  <= f_data(r_seq, 12'd0);
                        r_tkeep  <= w_first_last ? r_last_keep : '1;
                        r_tlast  <= w_first_last;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign packets_sent    = r_sent;
    assign axis_out.tdata  = r_tdata;
    assign axis_out.tkeep  = r_tkeep;
    assign axis_out.tuser  = '0;
    assign axis_out.tlast  = r_tlast;
    assign axis_out.tvalid = r_tvalid;

endmodule

`default_nettype wire
